// File: rtl/sim_ioctl_sram_loader.sv
// Streams ioctl download bytes into an SRAM through a small write FIFO and a 3-cycle write FSM;
// hands the SRAM back to the core when idle. Optional readback path enabled by SIM_LOADER_UPLOAD_EN.
module sim_ioctl_sram_loader #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CH     = 2,
  parameter int INDEX_BASE = 0,
  parameter int CH_SHIFT   = 19
) (
  input  logic              clk_28_636,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [DATA_W-1:0] ioctl_din,
  output logic              ioctl_wait,
  input  logic              host_we_n,
  input  logic [ADDR_W-1:0] host_a,
  input  logic [DATA_W-1:0] host_d,
  output logic              SRAM_WE_n,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] sram_d_out,
  output logic              sram_d_oe,
  input  logic [DATA_W-1:0] sram_d_in,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  state_t             state;
  logic               we_n_q, wait_q, busy_q, dl_q;
  logic               in_range, accept, full, push, pop;
  logic [7:0]         ch_off;
  logic [ADDR_W-1:0]  map_addr;
  logic               up_active, up_wait;

  assign in_range = ({24'd0, ioctl_index} >= 32'(INDEX_BASE)) &&
                    ({24'd0, ioctl_index} <  32'(INDEX_BASE + NUM_CH));
  assign ch_off   = ioctl_index - 8'(INDEX_BASE);
  // Channel offset plus byte address, wrapping naturally at the SRAM size.
  assign map_addr = ADDR_W'(({24'd0, ch_off} << CH_SHIFT) + {7'd0, ioctl_addr});

  assign accept     = ioctl_wr & ioctl_download & in_range;
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign push       = accept & ~full;
  assign pop        = (state == HOLD);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign head       = mem[rd_ptr];

  assign busy       = ioctl_download | (count != '0) | (state != IDLE) | up_active;
  assign ioctl_wait = wait_q | up_wait;

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_28_636) begin
    if (push) mem[wr_ptr] <= '{addr: map_addr, data: ioctl_dout};
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_28_636 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      we_n_q   <= 1'b1;
      wait_q   <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy_q   <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      busy_q <= busy;
      done   <= busy_q & ~busy;
      count  <= count_next;
      wait_q <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (accept && full)                  overflow <= 1'b1;
      else if (ioctl_download && !dl_q)    overflow <= 1'b0;

      case (state)
        IDLE:   if (count != '0) state <= SETUP;
        SETUP:  begin state <= STROBE; we_n_q <= 1'b0; end
        STROBE: begin state <= HOLD;   we_n_q <= 1'b1; end
        HOLD:   state <= (count_next != '0) ? SETUP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIM_LOADER_UPLOAD_EN
  logic [ADDR_W-1:0] up_addr_q;
  logic [1:0]        up_cnt;
  logic              up_q, up_change;

  assign up_active = ioctl_upload & ~ioctl_download & in_range & (count == '0) & (state == IDLE);
  assign up_change = up_active & (~up_q | (map_addr != up_addr_q));
  assign up_wait   = (up_cnt != 2'd0);

  // Readback: two cycles of SRAM access time after every new address.
  always_ff @(posedge clk_28_636 or posedge reset) begin
    if (reset) begin
      up_addr_q <= '0;
      up_cnt    <= 2'd0;
      up_q      <= 1'b0;
      ioctl_din <= '0;
    end else begin
      up_q <= up_active;
      if (up_change) begin
        up_cnt    <= 2'd2;
        up_addr_q <= map_addr;
      end else if (!up_active) begin
        up_cnt <= 2'd0;
      end else if (up_cnt != 2'd0) begin
        up_cnt <= up_cnt - 2'd1;
        if (up_cnt == 2'd1) ioctl_din <= sram_d_in;
      end
    end
  end
`else
  logic unused_upload;
  assign up_active     = 1'b0;
  assign up_wait       = 1'b0;
  assign ioctl_din     = '0;
  assign unused_upload = ^{ioctl_upload, sram_d_in};
`endif

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    SRAM_WE_n  = host_we_n;
    SRAM_A     = host_a;
    sram_d_out = host_d;
    sram_d_oe  = ~host_we_n;
    if (reset) begin
      SRAM_WE_n = 1'b1;
      sram_d_oe = 1'b0;
    end else if (busy) begin
      SRAM_WE_n  = we_n_q;
      SRAM_A     = up_active ? map_addr : head.addr;
      sram_d_out = head.data;
      sram_d_oe  = (state != IDLE);
    end
  end

endmodule

// File: tb/tb_sim_ioctl_sram_loader.sv
// Randomized self-checking bench for sim_ioctl_sram_loader; the SRAM side is observed by a write
// monitor and compared with an address-mapping model. Define SIM_LOADER_UPLOAD_EN to test readback.
module tb_sim_ioctl_sram_loader;
  localparam int AW = 21;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [DW-1:0] ioctl_dout = '0;
  logic [7:0]    ioctl_index = '0;
  logic [DW-1:0] ioctl_din;
  logic          ioctl_wait;
  logic          host_we_n = 1'b1;
  logic [AW-1:0] host_a = '0;
  logic [DW-1:0] host_d = '0;
  logic          SRAM_WE_n;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] sram_d_out;
  logic          sram_d_oe;
  logic [DW-1:0] sram_d_in;
  logic          busy, done, overflow;

  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign sram_d_in = (SRAM_A == pre_addr) ? pre_data : '0;

  always #5 clk = ~clk;

  sim_ioctl_sram_loader dut (
    .clk_28_636(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .host_we_n(host_we_n), .host_a(host_a), .host_d(host_d),
    .SRAM_WE_n(SRAM_WE_n), .SRAM_A(SRAM_A), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe),
    .sram_d_in(sram_d_in), .busy(busy), .done(done), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Write monitor: one record per low period of SRAM_WE_n, with its length in cycles.
  logic [AW-1:0] mon_a[$];
  logic [DW-1:0] mon_d[$];
  int            mon_len[$];
  int            low_len = 0, oe_bad = 0, done_cnt = 0, done_long = 0;
  logic [AW-1:0] cap_a;
  logic [DW-1:0] cap_d;
  bit            done_prev = 0;

  always @(negedge clk) begin
    if (SRAM_WE_n === 1'b0) begin
      low_len++;
      cap_a = SRAM_A;
      cap_d = sram_d_out;
      if (sram_d_oe !== 1'b1) oe_bad++;
    end else if (low_len > 0) begin
      mon_a.push_back(cap_a);
      mon_d.push_back(cap_d);
      mon_len.push_back(low_len);
      low_len = 0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) done_long++;
    end
    done_prev = (done === 1'b1);
  end

  // Reference model: expected SRAM writes in issue order.
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];

  function automatic logic [AW-1:0] map_addr(int k, logic [24:0] a);
    longint s;
    s = (longint'(k) << 19) + longint'(a);
    return s[AW-1:0];
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_a.delete(); mon_d.delete(); mon_len.delete();
    exp_a.delete(); exp_d.delete();
    oe_bad = 0; done_cnt = 0; done_long = 0;
  endtask

  task automatic wr(int idx, logic [24:0] a, logic [DW-1:0] d);
    ioctl_index = 8'(idx);
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int i;
    for (i = 0; i < 300 && busy !== 1'b0; i++) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: busy still %b after 300 cycles, required 0", name, busy);
    end
    tick(3);
  endtask

  task automatic test_reset();
    host_we_n = 1'b0;
    host_a = 21'h12345;
    host_d = 8'h99;
    #1;
    n_cmp++; if (SRAM_WE_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", SRAM_WE_n); end
    n_cmp++; if (sram_d_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", sram_d_oe); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
    n_cmp++; if (ioctl_din !== '0) begin n_bad++; $display("FAIL reset_din: got %h want 00", ioctl_din); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (SRAM_WE_n !== 1'b0 || SRAM_A !== host_a || sram_d_out !== host_d || sram_d_oe !== 1'b1) begin
      n_bad++; $display("FAIL reset_passthru: we_n=%b a=%h d=%h oe=%b want 0/%h/%h/1", SRAM_WE_n, SRAM_A, sram_d_out, sram_d_oe, host_a, host_d);
    end
    host_we_n = 1'b1;
    tick(2);
    clear_mon();
  endtask

  task automatic check_writes(string name);
    n_cmp++;
    if (mon_a.size() != exp_a.size()) begin
      n_bad++; $display("FAIL %s_count: got %0d writes want %0d", name, mon_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        n_cmp++;
        if (mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i] || mon_len[i] != 1) begin
          n_bad++; $display("FAIL %s_write%0d: got a=%h d=%h low=%0d want a=%h d=%h low=1", name, i, mon_a[i], mon_d[i], mon_len[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_cmp++; if (oe_bad != 0) begin n_bad++; $display("FAIL %s_oe: %0d strobe cycles without oe, want 0", name, oe_bad); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] dat [3];
    dat[0] = 8'hA5; dat[1] = 8'h5A; dat[2] = 8'hFF;
    clear_mon();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back(map_addr(1, 25'(i)));
      exp_d.push_back(dat[i]);
      wr(1, 25'(i), dat[i]);
    end
    ioctl_download = 1'b0;
    wait_idle("basic");
    check_writes("basic");
    n_cmp++; if (exp_a[0] !== 21'h80000) begin n_bad++; $display("FAIL basic_base: got %h want 80000", exp_a[0]); end
    n_cmp++; if (done_cnt != 1 || done_long != 0) begin n_bad++; $display("FAIL basic_done: pulses=%0d long=%0d want 1/0", done_cnt, done_long); end
  endtask

  task automatic test_random_download();
    for (int it = 0; it < 5; it++) begin
      int k, n, guard;
      logic [24:0] a;
      logic [DW-1:0] d;
      clear_mon();
      k = $urandom_range(0, 1);
      n = $urandom_range(3, 10);
      ioctl_download = 1'b1;
      tick();
      for (int j = 0; j < n; j++) begin
        guard = 0;
        while (ioctl_wait === 1'b1 && guard < 50) begin tick(); guard++; end
        a = (j == 0 && it == 0) ? 25'h1FFFFFF : 25'($urandom);
        d = 8'($urandom);
        exp_a.push_back(map_addr(k, a));
        exp_d.push_back(d);
        wr(k, a, d);
        if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
      end
      ioctl_download = 1'b0;
      wait_idle("random");
      check_writes("random");
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL random_overflow: got %b want 0", overflow); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL random_done: pulses=%0d want 1", done_cnt); end
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] sa[6];
    logic [DW-1:0] sd[6];
    clear_mon();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      sd[i] = 8'($urandom);
      sa[i] = map_addr(0, 25'(8'h40 + i));
      wr(0, 25'(8'h40 + i), sd[i]);
      if (i == 2) begin
        n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL ovf_wait: got %b want 1 after third write", ioctl_wait); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    ioctl_download = 1'b0;
    wait_idle("ovf");
    // Depth 4 with at most one drain in six cycles: first four kept in order, at least one dropped.
    n_cmp++;
    if (mon_a.size() < 4 || mon_a.size() > 5) begin
      n_bad++; $display("FAIL ovf_count: got %0d writes want 4 or 5", mon_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (mon_a[i] !== sa[i] || mon_d[i] !== sd[i]) begin
          n_bad++; $display("FAIL ovf_write%0d: got a=%h d=%h want a=%h d=%h", i, mon_a[i], mon_d[i], sa[i], sd[i]);
        end
      end
      if (mon_a.size() == 5) begin
        n_cmp++;
        if (!((mon_a[4] === sa[4] && mon_d[4] === sd[4]) || (mon_a[4] === sa[5] && mon_d[4] === sd[5]))) begin
          n_bad++; $display("FAIL ovf_write4: got a=%h d=%h want entry 4 or 5", mon_a[4], mon_d[4]);
        end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ioctl_download = 1'b1;
    tick();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    ioctl_download = 1'b0;
    tick(3);
  endtask

  task automatic test_drain_after_fall();
    logic [DW-1:0] d;
    clear_mon();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      exp_a.push_back(map_addr(0, 25'(100 + i)));
      exp_d.push_back(d);
      wr(0, 25'(100 + i), d);
    end
    ioctl_download = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy: got %b want 1", busy); end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL drain_early_done: pulses=%0d want 0", done_cnt); end
    wait_idle("drain");
    check_writes("drain");
    n_cmp++; if (done_cnt != 1 || done_long != 0) begin n_bad++; $display("FAIL drain_done: pulses=%0d long=%0d want 1/0", done_cnt, done_long); end
  endtask

  task automatic test_reset_mid_strobe();
    int guard;
    logic [DW-1:0] d;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) wr(1, 25'(i), 8'($urandom));
    guard = 0;
    while (SRAM_WE_n !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    n_cmp++; if (SRAM_WE_n !== 1'b0) begin n_bad++; $display("FAIL rst_strobe_seen: got we_n=%b want 0", SRAM_WE_n); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (SRAM_WE_n !== 1'b1) begin n_bad++; $display("FAIL rst_we_n: got %b want 1 immediately", SRAM_WE_n); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    tick(2);
    clear_mon();
    d = 8'($urandom);
    exp_a.push_back(map_addr(0, 25'd7));
    exp_d.push_back(d);
    ioctl_index = 8'd0; ioctl_addr = 25'd7; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (overflow !== 1'b0 || ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL rst_release: overflow=%b wait=%b want 0/0", overflow, ioctl_wait); end
    tick();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    wait_idle("rst");
    check_writes("rst");
  endtask

  task automatic test_bad_index_and_host();
    clear_mon();
    ioctl_download = 1'b1;
    tick();
    wr(5, 25'h10, 8'h11);
    wr(2, 25'h11, 8'h22);
    tick(10);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL badidx_busy: got %b want 1", busy); end
    host_we_n = 1'b0; host_a = 21'($urandom); host_d = 8'($urandom);
    #1;
    n_cmp++; if (SRAM_WE_n !== 1'b1 || sram_d_oe !== 1'b0) begin n_bad++; $display("FAIL host_blocked: we_n=%b oe=%b want 1/0", SRAM_WE_n, sram_d_oe); end
    host_we_n = 1'b1;
    ioctl_download = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badidx_busy_fall: got %b want 0", busy); end
    wr(1, 25'h12, 8'h33);
    tick(6);
    n_cmp++; if (mon_a.size() != 0) begin n_bad++; $display("FAIL badidx_writes: got %0d want 0", mon_a.size()); end
    for (int i = 0; i < 3; i++) begin
      host_we_n = i[0]; host_a = 21'($urandom); host_d = 8'($urandom);
      #1;
      n_cmp++;
      if (SRAM_WE_n !== host_we_n || SRAM_A !== host_a || sram_d_out !== host_d || sram_d_oe !== ~host_we_n) begin
        n_bad++; $display("FAIL host_passthru%0d: we_n=%b a=%h d=%h oe=%b want %b/%h/%h/%b", i, SRAM_WE_n, SRAM_A, sram_d_out, sram_d_oe, host_we_n, host_a, host_d, ~host_we_n);
      end
    end
    host_we_n = 1'b1;
    tick(2);
    clear_mon();
  endtask

  task automatic test_upload();
    pre_addr = 21'h80010;
    pre_data = 8'h3C;
    host_a = 21'h00abc;
    ioctl_index = 8'd1; ioctl_addr = 25'h10; ioctl_upload = 1'b1;
`ifdef SIM_LOADER_UPLOAD_EN
    #1;
    n_cmp++; if (busy !== 1'b1 || SRAM_A !== 21'h80010) begin n_bad++; $display("FAIL up_addr: busy=%b a=%h want 1/80010", busy, SRAM_A); end
    tick();
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL up_wait1: got %b want 1", ioctl_wait); end
    tick();
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL up_wait2: got %b want 1", ioctl_wait); end
    tick();
    n_cmp++; if (ioctl_din !== 8'h3C || ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL up_data: din=%h wait=%b want 3c/0", ioctl_din, ioctl_wait); end
`else
    tick(3);
    n_cmp++; if (busy !== 1'b0 || ioctl_din !== '0 || ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL up_ignored: busy=%b din=%h wait=%b want 0/00/0", busy, ioctl_din, ioctl_wait); end
    n_cmp++; if (SRAM_A !== host_a) begin n_bad++; $display("FAIL up_passthru: a=%h want %h", SRAM_A, host_a); end
`endif
    ioctl_upload = 1'b0;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_download();
    test_overflow();
    test_drain_after_fall();
    test_reset_mid_strobe();
    test_bad_index_and_host();
    test_upload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sim_ioctl_sram_loader.md
SIM_IOCTL_SRAM_LOADER -- requirements
Module: sim_ioctl_sram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, meaning SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning SRAM/ioctl data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning write FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter NUM_CH, default 2, meaning number of download channels (1..4).
REQ-005 SHALL have parameter INDEX_BASE, default 0, meaning ioctl_index of channel 0; channel k uses INDEX_BASE+k.
REQ-006 SHALL have parameter CH_SHIFT, default 19, meaning channel k base address = k << CH_SHIFT.
REQ-007 SHALL have port clk_28_636  in  1  sole clock; all logic rising-edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have ports ioctl_download/ioctl_upload/ioctl_wr  in  1 each  ioctl strobes/levels.
REQ-010 SHALL have ports ioctl_addr  in  25, ioctl_dout  in  DATA_W, ioctl_index  in  8.
REQ-011 SHALL have ports ioctl_din  out  DATA_W and ioctl_wait  out  1.
REQ-012 SHALL have ports host_we_n  in  1, host_a  in  ADDR_W, host_d  in  DATA_W  (core SRAM request).
REQ-013 SHALL have ports SRAM_WE_n  out  1, SRAM_A  out  ADDR_W, sram_d_out  out  DATA_W, sram_d_oe  out  1, sram_d_in  in  DATA_W.
REQ-014 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), overflow  out  1 (sticky).

Function
REQ-015 SHALL accept an ioctl_wr cycle only while ioctl_download=1 and ioctl_index in [INDEX_BASE, INDEX_BASE+NUM_CH-1]; others ignored.
REQ-016 SHALL push {(k<<CH_SHIFT)+ioctl_addr truncated to ADDR_W, ioctl_dout} into the FIFO on accept; sum wraps modulo 2^ADDR_W.
REQ-017 SHALL assert ioctl_wait combinationally-registered (next cycle) when FIFO count >= FIFO_DEPTH-1, deassert when count <= FIFO_DEPTH-2.
REQ-018 SHALL drop an accepted write arriving with FIFO full and set overflow; overflow clears only on reset or rising edge of ioctl_download.
REQ-019 SHALL drain FIFO via FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE (or SETUP if FIFO non-empty); 3 cycles per write.
REQ-020 SETUP: drive SRAM_A/sram_d_out from FIFO head, sram_d_oe=1, SRAM_WE_n=1; STROBE: SRAM_WE_n=0; HOLD: SRAM_WE_n=1, pop FIFO.
REQ-021 Simultaneous push and pop in one cycle SHALL leave count unchanged and lose no data.
REQ-022 busy SHALL be 1 while ioctl_download=1 or FIFO non-empty or FSM not IDLE.
REQ-023 done SHALL pulse one cycle when busy falls 1->0.
REQ-024 ioctl_download falling with FIFO non-empty SHALL NOT abort; drain completes, then done.
REQ-025 While busy=0, SRAM_WE_n/SRAM_A/sram_d_out SHALL equal host_we_n/host_a/host_d combinationally, sram_d_oe = ~host_we_n.
REQ-026 While busy=1, host requests SHALL be ignored (no buffering).

Reset
REQ-027 Reset SHALL asynchronously force FSM=IDLE, FIFO empty, SRAM_WE_n=1, sram_d_oe=0, ioctl_wait=0, overflow=0, done=0, ioctl_din=0.
REQ-028 Reset asserted during STROBE SHALL raise SRAM_WE_n the same instant; the in-flight entry is discarded.
REQ-029 After reset release, first accept possible on the first clock edge.

Configuration
REQ-030 Macro SIM_LOADER_UPLOAD_EN SHALL, when defined, enable readback: ioctl_upload=1 with matching index drives SRAM_A from mapped ioctl_addr (busy=1) and ioctl_din = sram_d_in registered 2 cycles after address change, ioctl_wait=1 for those 2 cycles.
REQ-031 Without SIM_LOADER_UPLOAD_EN, ioctl_upload SHALL be ignored and ioctl_din held 0.

Verification
REQ-032 Defaults; download index 1, 3 writes addr 0..2 data A5,5A,FF -> SRAM writes at 0x80000..0x80002, WE_n low exactly 1 cycle each, done pulse once.
REQ-033 FIFO_DEPTH=4; 6 back-to-back ioctl_wr ignoring ioctl_wait -> ioctl_wait high after 3rd, overflow=1, dropped entries never written.
REQ-034 Download falls with 3 entries queued -> 3 more writes complete, then busy=0 and done=1 for one cycle.
REQ-035 Reset asserted mid-STROBE -> SRAM_WE_n=1 immediately, FIFO empty, overflow=0 after release.
REQ-036 Index outside range (e.g. 5) with ioctl_wr -> no SRAM write, busy follows ioctl_download only; host passthrough resumes when download=0.
REQ-037 With SIM_LOADER_UPLOAD_EN: preload 0x80010=3C, upload index 1 addr 0x10 -> ioctl_din=3C two cycles later, ioctl_wait high those 2 cycles.
